// File: rtl/ft_recovery_ctrl_pkg.sv
// ft_pkg -- shared types for the fault-tolerant recovery controller.
//   rec_state_e   : recovery FSM state encoding
//   ERR_CNT_WIDTH : width of the optional mismatch event counter
package ft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HALT    = 3'd1,
      ST_RESTORE = 3'd2,
      ST_RESUME  = 3'd3,
      ST_FAIL    = 3'd4
   } rec_state_e;

   localparam int ERR_CNT_WIDTH = 8;

endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// ft_recovery_ctrl_if -- bundle between the recovery controller and the
// lock-step core pair / shared GPR recovery port.
//   mismatch_i, halt_ack_a_i, halt_ack_b_i, sgpr_rdata_i : into the controller
//   halt_o, sgpr_raddr_o, restore_we_o, restore_addr_o,
//   restore_data_o, resume_o, busy_o, fatal_o            : from the controller
//   err_count_o : mismatch event counter, present only with FT_ERR_COUNT_EN
// slave modport = controller side, master modport = core/environment side.
interface ft_recovery_ctrl_if
   import ft_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  mismatch_i;
   logic                  halt_ack_a_i;
   logic                  halt_ack_b_i;
   logic [DATA_WIDTH-1:0] sgpr_rdata_i;
   logic                  halt_o;
   logic [ADDR_WIDTH-1:0] sgpr_raddr_o;
   logic                  restore_we_o;
   logic [ADDR_WIDTH-1:0] restore_addr_o;
   logic [DATA_WIDTH-1:0] restore_data_o;
   logic                  resume_o;
   logic                  busy_o;
   logic                  fatal_o;
`ifdef FT_ERR_COUNT_EN
   logic [ERR_CNT_WIDTH-1:0] err_count_o;
`endif

   modport slave (
      input  mismatch_i, halt_ack_a_i, halt_ack_b_i, sgpr_rdata_i,
      output halt_o, sgpr_raddr_o, restore_we_o, restore_addr_o,
             restore_data_o, resume_o, busy_o, fatal_o
`ifdef FT_ERR_COUNT_EN
      , output err_count_o
`endif
   );

   modport master (
      output mismatch_i, halt_ack_a_i, halt_ack_b_i, sgpr_rdata_i,
      input  halt_o, sgpr_raddr_o, restore_we_o, restore_addr_o,
             restore_data_o, resume_o, busy_o, fatal_o
`ifdef FT_ERR_COUNT_EN
      , input err_count_o
`endif
   );

endinterface

// File: rtl/ft_recovery_ctrl_halt_timer.sv
// ft_halt_timer -- 16-bit wait counter for the HALT phase.
//   clk, rst  : clock, async active-high reset
//   en_i      : high while the FSM sits in HALT; low clears the count
//   timeout_o : high in the HALT cycle whose count equals HALT_TIMEOUT-1
module ft_halt_timer #(
   parameter int HALT_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic timeout_o
);

   logic [15:0] cnt_q, cnt_d;

   // Count is 0 in the first HALT cycle and advances once per HALT cycle.
   always_comb begin
      cnt_d = '0;
      if (en_i) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign timeout_o = en_i && (cnt_q == 16'(HALT_TIMEOUT - 1));

endmodule

// File: rtl/ft_recovery_ctrl.sv
// ft_recovery_ctrl -- lock-step mismatch recovery sequencer.
// On a comparator mismatch it halts both cores, waits (bounded) for both
// halt acks, copies registers 1..2**ADDR_WIDTH-1 from the shared GPR port
// into both register files (one per cycle), then pulses resume. A halt
// that is never fully acknowledged ends in a sticky FAIL state.
//   clk, rst : clock, async active-high reset
//   bus      : ft_recovery_ctrl_if.slave (see interface header)
// Optional feature macro FT_ERR_COUNT_EN adds bus.err_count_o, a
// saturating count of IDLE->HALT transitions.
module ft_recovery_ctrl
   import ft_pkg::*;
#(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int HALT_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   ft_recovery_ctrl_if.slave     bus
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

   rec_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  timeout;

   ft_halt_timer #(.HALT_TIMEOUT(HALT_TIMEOUT)) u_halt_timer (
      .clk       (clk),
      .rst       (rst),
      .en_i      (state_q == ST_HALT),
      .timeout_o (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      addr_d             = '0;
      bus.halt_o         = 1'b0;
      bus.sgpr_raddr_o   = '0;
      bus.restore_we_o   = 1'b0;
      bus.restore_addr_o = '0;
      bus.restore_data_o = '0;
      bus.resume_o       = 1'b0;
      bus.busy_o         = 1'b0;
      bus.fatal_o        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.mismatch_i) state_d = ST_HALT;
         end
         ST_HALT: begin
            bus.halt_o = 1'b1;
            bus.busy_o = 1'b1;
            // Both acks win over a timeout landing in the same cycle.
            if (bus.halt_ack_a_i && bus.halt_ack_b_i) begin
               state_d = ST_RESTORE;
               addr_d  = ADDR_FIRST;   // x0 is hard-wired, never restored
            end else if (timeout) begin
               state_d = ST_FAIL;
            end
         end
         ST_RESTORE: begin
            bus.halt_o         = 1'b1;
            bus.busy_o         = 1'b1;
            bus.restore_we_o   = 1'b1;
            bus.sgpr_raddr_o   = addr_q;
            bus.restore_addr_o = addr_q;
            bus.restore_data_o = bus.sgpr_rdata_i;
            // Hold at the top address instead of wrapping to x0.
            if (addr_q == ADDR_LAST) begin
               addr_d  = addr_q;
               state_d = ST_RESUME;
            end else begin
               addr_d  = addr_q + ADDR_FIRST;
            end
         end
         ST_RESUME: begin
            bus.resume_o = 1'b1;
            bus.busy_o   = 1'b1;
            state_d      = ST_IDLE;   // mismatch here is deliberately dropped
         end
         ST_FAIL: begin
            bus.halt_o  = 1'b1;
            bus.fatal_o = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef FT_ERR_COUNT_EN
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == ST_IDLE) && bus.mismatch_i && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign bus.err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Scoreboard bench for ft_recovery_ctrl: stimulus pushes expected restore
// writes / resume pulses, a negedge monitor pops and compares them.
module tb_ft_recovery_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ft_recovery_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus();

   ft_recovery_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .HALT_TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Shared GPR contents: distinct value per register.
   function automatic logic [31:0] gpr_val(input logic [4:0] a);
      return 32'hC0DE_0000 + ({27'd0, a} * 32'h111);
   endfunction
   assign bus.sgpr_rdata_i = gpr_val(bus.sgpr_raddr_o);

   typedef struct {
      bit          is_resume;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_writes(input int last, input bit with_resume);
      for (int a = 1; a <= last; a++)
         exp_q.push_back('{is_resume: 1'b0, addr: 5'(a), data: gpr_val(5'(a))});
      if (with_resume) exp_q.push_back('{is_resume: 1'b1, addr: 5'd0, data: 32'd0});
   endtask

   // Monitor: every restore write or resume pulse must match the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.restore_we_o || bus.resume_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: we=%0b resume=%0b addr=%0d, nothing expected",
                        bus.restore_we_o, bus.resume_o, bus.restore_addr_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.is_resume !== bus.resume_o || mon_e.is_resume === bus.restore_we_o ||
                   (!mon_e.is_resume && (bus.restore_addr_o !== mon_e.addr ||
                    bus.sgpr_raddr_o !== mon_e.addr || bus.restore_data_o !== mon_e.data))) begin
                  errors++;
                  $display("FAIL scoreboard: got we=%0b resume=%0b addr=%0d raddr=%0d data=%0h expected resume=%0b addr=%0d data=%0h",
                           bus.restore_we_o, bus.resume_o, bus.restore_addr_o, bus.sgpr_raddr_o,
                           bus.restore_data_o, mon_e.is_resume, mon_e.addr, mon_e.data);
               end
            end
         end
         if (!bus.restore_we_o) begin
            checks++;
            if (bus.restore_addr_o !== 5'd0 || bus.sgpr_raddr_o !== 5'd0 || bus.restore_data_o !== 32'd0) begin
               errors++;
               $display("FAIL idle_bus_zero: addr=%0d raddr=%0d data=%0h expected all 0",
                        bus.restore_addr_o, bus.sgpr_raddr_o, bus.restore_data_o);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.mismatch_i = 1'b0;
      bus.halt_ack_a_i = 1'b0;
      bus.halt_ack_b_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // One full recovery; acks arrive d cycles after HALT entry (count = d).
   // mid: pulse mismatch around restore address 10.
   // chain: leave mismatch high through RESUME so the next call restarts.
   task automatic do_recovery(input int d, input bit mid, input bit chain);
      bit seen;
      push_writes(31, 1'b1);
      bus.mismatch_i = 1'b1;
      tick();
      bus.mismatch_i = 1'b0;
      chk("halt_on_entry", bus.halt_o, 1);
      chk("busy_on_entry", bus.busy_o, 1);
      repeat (d) tick();
      bus.halt_ack_a_i = 1'b1;
      bus.halt_ack_b_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         tick();
         if (mid) begin
            if (bus.restore_addr_o == 5'd10) bus.mismatch_i = 1'b1;
            else if (bus.restore_addr_o == 5'd12) bus.mismatch_i = 1'b0;
         end
         seen = bus.resume_o;
      end
      chk("resume_seen", {31'd0, seen}, 1);
      chk("halt_low_at_resume", bus.halt_o, 0);
      bus.halt_ack_a_i = 1'b0;
      bus.halt_ack_b_i = 1'b0;
      bus.mismatch_i = chain;
      tick();
      chk("busy_after_resume", bus.busy_o, 0);
      chk("halt_after_resume", bus.halt_o, 0);
      chk("resume_one_cycle", bus.resume_o, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.mismatch_i = 1'b0;
      bus.halt_ack_a_i = 1'b0;
      bus.halt_ack_b_i = 1'b0;
      #1;
      chk("rst_halt", bus.halt_o, 0);
      chk("rst_we", bus.restore_we_o, 0);
      chk("rst_resume", bus.resume_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_fatal", bus.fatal_o, 0);
      tick();
      rst = 1'b0;
      tick();

      // Basic recovery, acks 3 cycles after halt.
      do_recovery(3, 1'b0, 1'b0);
      // Acks in the very last allowed HALT cycle.
      do_recovery(15, 1'b0, 1'b0);
      // Mismatch pulses during RESTORE are ignored.
      do_recovery(3, 1'b1, 1'b0);
      // Mismatch during RESUME ignored; held into IDLE it restarts.
      do_recovery(2, 1'b0, 1'b1);
      do_recovery(0, 1'b0, 1'b0);

      // Single ack only -> FAIL after HALT_TIMEOUT cycles.
      bus.halt_ack_a_i = 1'b1;
      bus.mismatch_i = 1'b1;
      tick();
      bus.mismatch_i = 1'b0;
      repeat (15) tick();
      chk("fail_not_yet", bus.fatal_o, 0);
      chk("halt_last_wait", bus.halt_o, 1);
      tick();
      chk("fail_fatal", bus.fatal_o, 1);
      chk("fail_halt", bus.halt_o, 1);
      chk("fail_busy", bus.busy_o, 0);
      bus.halt_ack_b_i = 1'b1;
      bus.mismatch_i = 1'b1;
      repeat (5) tick();
      chk("fail_sticky_fatal", bus.fatal_o, 1);
      chk("fail_sticky_halt", bus.halt_o, 1);
      rst = 1'b1;
      #1;
      chk("fail_rst_fatal", bus.fatal_o, 0);
      chk("fail_rst_halt", bus.halt_o, 0);
      bus.halt_ack_a_i = 1'b0;
      bus.halt_ack_b_i = 1'b0;
      bus.mismatch_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // Reset while restoring address 20 aborts without resume.
      push_writes(19, 1'b0);
      bus.mismatch_i = 1'b1;
      tick();
      bus.mismatch_i = 1'b0;
      repeat (2) tick();
      bus.halt_ack_a_i = 1'b1;
      bus.halt_ack_b_i = 1'b1;
      for (int i = 0; i < 60 && bus.restore_addr_o != 5'd20; i++) tick();
      chk("reached_addr20", bus.restore_addr_o, 20);
      rst = 1'b1;
      #1;
      chk("abort_we", bus.restore_we_o, 0);
      chk("abort_addr", bus.restore_addr_o, 0);
      chk("abort_halt", bus.halt_o, 0);
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_resume", bus.resume_o, 0);
      bus.halt_ack_a_i = 1'b0;
      bus.halt_ack_b_i = 1'b0;
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("abort_idle", bus.busy_o, 0);

`ifdef FT_ERR_COUNT_EN
      do_reset();
      chk("errcnt_reset", 32'(bus.err_count_o), 0);
      do_recovery(1, 1'b0, 1'b0);
      chk("errcnt_one", 32'(bus.err_count_o), 1);
      for (int n = 1; n < 260; n++) do_recovery(1, 1'b0, 1'b0);
      chk("errcnt_saturate", 32'(bus.err_count_o), 255);
      rst = 1'b1;
      #1;
      chk("errcnt_rst", 32'(bus.err_count_o), 0);
      tick();
      rst = 1'b0;
      tick();
`endif

      tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ft_recovery_ctrl.md
FT_RECOVERY_CTRL -- requirements
Module: ft_recovery_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the register address width; register count is 2**ADDR_WIDTH.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the register data width.
REQ-003 The block SHALL have parameter HALT_TIMEOUT, default 16, meaning the maximum number of cycles to wait for both halt acknowledges.
REQ-004 Port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port mismatch_i  input  1  comparator mismatch flag; high means the two cores' writebacks disagree.
REQ-007 Port halt_ack_a_i  input  1  core A is halted.
REQ-008 Port halt_ack_b_i  input  1  core B is halted.
REQ-009 Port sgpr_rdata_i  input  DATA_WIDTH  combinational read data from the shared GPR recovery port.
REQ-010 Port halt_o  output  1  halt request to both cores.
REQ-011 Port sgpr_raddr_o  output  ADDR_WIDTH  shared GPR recovery read address.
REQ-012 Port restore_we_o  output  1  write enable into both cores' register files.
REQ-013 Port restore_addr_o  output  ADDR_WIDTH  restore write address.
REQ-014 Port restore_data_o  output  DATA_WIDTH  restore write data.
REQ-015 Port resume_o  output  1  one-cycle pulse that releases the cores.
REQ-016 Port busy_o  output  1  high in any state other than IDLE and FAIL.
REQ-017 Port fatal_o  output  1  sticky flag: recovery failed.

Function
REQ-018 The FSM SHALL have the states IDLE, HALT, RESTORE, RESUME and FAIL.
REQ-019 In IDLE, mismatch_i=1 SHALL cause a transition to HALT on the next edge, with halt_o=1 from that cycle onward.
REQ-020 In HALT, a 16-bit wait counter SHALL start at 0 and increment each cycle.
REQ-021 In HALT, both acks high in the same cycle SHALL cause a transition to RESTORE, with the address counter loaded to 1.
REQ-022 In HALT, when the wait counter reaches HALT_TIMEOUT-1 without both acks, the FSM SHALL transition to FAIL; a single ack is insufficient.
REQ-023 In RESTORE: sgpr_raddr_o=restore_addr_o=counter, restore_data_o=sgpr_rdata_i, restore_we_o=1; the counter increments each cycle; exactly one register is restored per cycle.
REQ-024 Register x0 SHALL never be restored, so RESTORE lasts exactly 2**ADDR_WIDTH-1 cycles (31 by default).
REQ-025 The counter SHALL stop at the all-ones address; the cycle after the last write SHALL go to RESUME, with no wrap-around write to address 0.
REQ-026 In RESUME, the block SHALL assert resume_o for exactly 1 cycle, deassert halt_o in that same cycle, and return to IDLE.
REQ-027 In FAIL, halt_o SHALL stay 1 and fatal_o SHALL be 1 until rst; all other inputs are ignored.
REQ-028 mismatch_i SHALL be ignored outside IDLE; no nested or queued recovery.
REQ-029 mismatch_i=1 in the same cycle as the RESUME→IDLE transition SHALL be ignored; a mismatch sampled in IDLE the following cycle starts a new recovery.
REQ-030 restore_we_o SHALL be 0 in every state except RESTORE.
REQ-031 sgpr_raddr_o, restore_addr_o and restore_data_o SHALL be 0 when restore_we_o=0.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, both counters to 0, and all outputs to 0, including fatal_o.
REQ-033 rst asserted mid-HALT or mid-RESTORE SHALL abort the sequence immediately; no resume_o pulse is generated.

Configuration
REQ-034 With FT_ERR_COUNT_EN defined, the block SHALL add output port err_count_o (8 bits), which increments on each IDLE→HALT transition and saturates at 255.
REQ-035 Without FT_ERR_COUNT_EN, the port SHALL be absent and no counter logic SHALL be present.
REQ-036 Whether or not FT_ERR_COUNT_EN is defined, all other behaviour SHALL be identical.

Structure
REQ-037 The package ft_pkg SHALL hold the FSM state enum (rec_state_e) and the localparam ERR_CNT_WIDTH=8.
REQ-038 The block SHALL contain one sub-module, ft_halt_timer (wait counter plus timeout compare), instantiated once; everything else is flat.

Verification
REQ-039 Reset, then a 1-cycle mismatch_i, both acks 3 cycles later → halt_o=1; writes to addresses 1..31 carrying sgpr_rdata_i in 31 consecutive cycles; one resume_o pulse; busy_o=0 afterwards.
REQ-040 Mismatch with only halt_ack_a_i high for HALT_TIMEOUT=16 cycles → FAIL, fatal_o=1, halt_o=1, and no restore_we_o pulse; both held until rst.
REQ-041 Mismatch pulses during RESTORE (address 10) → sequence unaffected, still 31 writes, one resume_o pulse.
REQ-042 rst asserted at restore address 20 → all outputs 0 immediately, FSM in IDLE, no resume_o pulse.
REQ-043 FT_ERR_COUNT_EN defined: 260 complete recoveries → err_count_o=255; a subsequent rst → 0.
